// File: rtl/load_store_pipe_responder.sv
// load_store_pipe_responder: accepts one load/store request, issues a byte-enabled
// word-aligned memory transaction and returns the aligned, zero-extended result.
module load_store_pipe_responder (
    input  logic        iCLOCK,
    input  logic        iRESET_SYNC,
    input  logic        iLDST_REQ,
    output logic        oLDST_BUSY,
    input  logic [1:0]  iLDST_ORDER,
    input  logic [3:0]  iLDST_MASK,
    input  logic        iLDST_RW,
    input  logic [13:0] iLDST_TID,
    input  logic [1:0]  iLDST_MMUMOD,
    input  logic [2:0]  iLDST_MMUPS,
    input  logic [31:0] iLDST_PDT,
    input  logic [31:0] iLDST_ADDR,
    input  logic [31:0] iLDST_DATA,
    output logic        oLDST_VALID,
    output logic [11:0] oLDST_MMU_FLAGS,
    output logic [31:0] oLDST_DATA,
    output logic        oMEM_REQ,
    input  logic        iMEM_BUSY,
    output logic        oMEM_RW,
    output logic [31:0] oMEM_ADDR,
    output logic [3:0]  oMEM_MASK,
    output logic [31:0] oMEM_DATA,
    output logic [13:0] oMEM_TID,
    output logic [1:0]  oMEM_MMUMOD,
    output logic [2:0]  oMEM_MMUPS,
    output logic [31:0] oMEM_PDT,
    input  logic        iMEM_VALID,
    input  logic [11:0] iMEM_MMU_FLAGS,
    input  logic [31:0] iMEM_DATA
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t      state_q, state_d;
    logic [1:0]  order_q, order_d, a_q, a_d, mmumod_q, mmumod_d;
    logic        rw_q, rw_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, pdt_q, pdt_d, data_q, data_d;
    logic [3:0]  mask_q, mask_d;
    logic [13:0] tid_q, tid_d;
    logic [2:0]  mmups_q, mmups_d;
    logic [11:0] flags_q, flags_d;
    logic [1:0]  a;
    logic        misaligned;
    logic [3:0]  base_mask;
    logic [31:0] shift_wdata, rword, lane_mask, rdata;

    always_comb begin
        a = iLDST_ADDR[1:0];
        misaligned = (iLDST_ORDER == 2'b01 && a[0]) || (iLDST_ORDER[1] && a != 2'b00);
        base_mask = iLDST_ORDER == 2'b00 ? 4'b0001 << a :
                    iLDST_ORDER == 2'b01 ? 4'b0011 << a : 4'b1111;
        shift_wdata = iLDST_ORDER == 2'b00 ? {24'h0, iLDST_DATA[7:0]} << {a, 3'b000} :
                      iLDST_ORDER == 2'b01 ? {16'h0, iLDST_DATA[15:0]} << {a, 3'b000} : iLDST_DATA;
        rword = iMEM_DATA >> {a_q, 3'b000};
        lane_mask = {{8{mask_q[3]}}, {8{mask_q[2]}}, {8{mask_q[1]}}, {8{mask_q[0]}}};
        rdata = rw_q ? 32'h0 :
                order_q == 2'b00 ? {24'h0, rword[7:0]} :
                order_q == 2'b01 ? {16'h0, a_q[1] ? iMEM_DATA[31:16] : iMEM_DATA[15:0]} :
                order_q == 2'b10 ? iMEM_DATA : iMEM_DATA & lane_mask;
        state_d  = state_q;
        order_d  = order_q;
        a_d      = a_q;
        rw_d     = rw_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        mask_d   = mask_q;
        tid_d    = tid_q;
        mmumod_d = mmumod_q;
        mmups_d  = mmups_q;
        pdt_d    = pdt_q;
        data_d   = data_q;
        flags_d  = flags_q;
        case (state_q)
            IDLE: if (iLDST_REQ) begin
                order_d  = iLDST_ORDER;
                a_d      = a;
                rw_d     = iLDST_RW;
                addr_d   = {iLDST_ADDR[31:2], 2'b00};
                wdata_d  = shift_wdata;
                mask_d   = base_mask & iLDST_MASK;
                tid_d    = iLDST_TID;
                mmumod_d = iLDST_MMUMOD;
                mmups_d  = iLDST_MMUPS;
                pdt_d    = iLDST_PDT;
                state_d  = misaligned ? RESP : ISSUE;
                // A misaligned access never reaches memory; it answers with the fault alone.
                if (misaligned) begin
                    data_d  = 32'h0;
                    flags_d = 12'h800;
                end
            end
            ISSUE: if (!iMEM_BUSY) state_d = WAIT;
            WAIT: if (iMEM_VALID) begin
                flags_d = iMEM_MMU_FLAGS & 12'h7FF;
                data_d  = rdata;
                state_d = RESP;
            end
            RESP: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state_q  <= IDLE;
            order_q  <= 2'b00;
            a_q      <= 2'b00;
            rw_q     <= 1'b0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            mask_q   <= 4'h0;
            tid_q    <= 14'h0;
            mmumod_q <= 2'b00;
            mmups_q  <= 3'b000;
            pdt_q    <= 32'h0;
            data_q   <= 32'h0;
            flags_q  <= 12'h0;
        end else begin
            state_q  <= state_d;
            order_q  <= order_d;
            a_q      <= a_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            mask_q   <= mask_d;
            tid_q    <= tid_d;
            mmumod_q <= mmumod_d;
            mmups_q  <= mmups_d;
            pdt_q    <= pdt_d;
            data_q   <= data_d;
            flags_q  <= flags_d;
        end
    end

    assign oLDST_BUSY      = state_q != IDLE;
    assign oLDST_VALID     = state_q == RESP;
    assign oLDST_DATA      = data_q;
    assign oLDST_MMU_FLAGS = flags_q;
    assign oMEM_REQ        = state_q == ISSUE;
    assign oMEM_RW         = rw_q;
    assign oMEM_ADDR       = addr_q;
    assign oMEM_MASK       = mask_q;
    assign oMEM_DATA       = wdata_q;
    assign oMEM_TID        = tid_q;
    assign oMEM_MMUMOD     = mmumod_q;
    assign oMEM_MMUPS      = mmups_q;
    assign oMEM_PDT        = pdt_q;
endmodule

// File: tb/tb_load_store_pipe_responder.sv
// tb_load_store_pipe_responder: directed vector table plus hand-written
// sequences for memory back-pressure and mid-transaction reset.
module tb_load_store_pipe_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ldst_req = 1'b0, ldst_rw = 1'b0;
    logic [1:0]  ldst_order = 2'b00, ldst_mmumod = 2'b00;
    logic [3:0]  ldst_mask = 4'h0;
    logic [13:0] ldst_tid = 14'h0;
    logic [2:0]  ldst_mmups = 3'b000;
    logic [31:0] ldst_pdt = 32'h0, ldst_addr = 32'h0, ldst_data = 32'h0;
    logic        ldst_busy, ldst_valid;
    logic [11:0] ldst_flags;
    logic [31:0] ldst_rdata;
    logic        mem_req, mem_busy = 1'b0, mem_rw, mem_valid = 1'b0;
    logic [31:0] mem_addr, mem_wdata, mem_pdt, mem_rdata = 32'h0;
    logic [3:0]  mem_mask;
    logic [13:0] mem_tid;
    logic [1:0]  mem_mmumod;
    logic [2:0]  mem_mmups;
    logic [11:0] mem_flags = 12'h0;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    load_store_pipe_responder dut (
        .iCLOCK(clk), .iRESET_SYNC(rst),
        .iLDST_REQ(ldst_req), .oLDST_BUSY(ldst_busy), .iLDST_ORDER(ldst_order),
        .iLDST_MASK(ldst_mask), .iLDST_RW(ldst_rw), .iLDST_TID(ldst_tid),
        .iLDST_MMUMOD(ldst_mmumod), .iLDST_MMUPS(ldst_mmups), .iLDST_PDT(ldst_pdt),
        .iLDST_ADDR(ldst_addr), .iLDST_DATA(ldst_data),
        .oLDST_VALID(ldst_valid), .oLDST_MMU_FLAGS(ldst_flags), .oLDST_DATA(ldst_rdata),
        .oMEM_REQ(mem_req), .iMEM_BUSY(mem_busy), .oMEM_RW(mem_rw), .oMEM_ADDR(mem_addr),
        .oMEM_MASK(mem_mask), .oMEM_DATA(mem_wdata), .oMEM_TID(mem_tid),
        .oMEM_MMUMOD(mem_mmumod), .oMEM_MMUPS(mem_mmups), .oMEM_PDT(mem_pdt),
        .iMEM_VALID(mem_valid), .iMEM_MMU_FLAGS(mem_flags), .iMEM_DATA(mem_rdata)
    );

    typedef struct {
        logic [1:0]  order;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic        rw;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [11:0] mflags;
        logic        mis;
        logic [3:0]  emask;
        logic [31:0] emdata;
        logic [31:0] edata;
        logic [11:0] eflags;
    } vec_t;
    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input vec_t v, input int i);
        ldst_req    = 1'b1;
        ldst_order  = v.order;
        ldst_addr   = v.addr;
        ldst_mask   = v.mask;
        ldst_rw     = v.rw;
        ldst_data   = v.wdata;
        ldst_tid    = 14'(14'h1000 + i);
        ldst_mmumod = 2'(i);
        ldst_mmups  = 3'(i + 1);
        ldst_pdt    = 32'hA5A50000 | 32'(i);
    endtask

    task automatic run_vec(input vec_t v, input int i);
        check("idle_before_req", {31'h0, ldst_busy}, 32'h0);
        drive_req(v, i);
        tick();
        ldst_req = 1'b0;
        check("busy_after_accept", {31'h0, ldst_busy}, 32'h1);
        if (v.mis) begin
            check("mis_no_mem_req", {31'h0, mem_req}, 32'h0);
            check("mis_valid", {31'h0, ldst_valid}, 32'h1);
            check("mis_data", ldst_rdata, v.edata);
            check("mis_flags", {20'h0, ldst_flags}, {20'h0, v.eflags});
        end else begin
            check("mem_req", {31'h0, mem_req}, 32'h1);
            check("mem_addr", mem_addr, {v.addr[31:2], 2'b00});
            check("mem_mask", {28'h0, mem_mask}, {28'h0, v.emask});
            check("mem_wdata", mem_wdata, v.emdata);
            check("mem_rw", {31'h0, mem_rw}, {31'h0, v.rw});
            check("mem_tid", {18'h0, mem_tid}, 32'h1000 + 32'(i));
            check("mem_pdt", mem_pdt, 32'hA5A50000 | 32'(i));
            check("mem_mmu", {27'h0, mem_mmups, mem_mmumod}, {27'h0, 3'(i + 1), 2'(i)});
            tick();
            check("wait_no_req", {31'h0, mem_req}, 32'h0);
            mem_valid = 1'b1;
            mem_rdata = v.rdata;
            mem_flags = v.mflags;
            tick();
            mem_valid = 1'b0;
            check("resp_valid", {31'h0, ldst_valid}, 32'h1);
            check("resp_data", ldst_rdata, v.edata);
            check("resp_flags", {20'h0, ldst_flags}, {20'h0, v.eflags});
        end
        tick();
        check("valid_one_cycle", {31'h0, ldst_valid}, 32'h0);
        check("data_held", ldst_rdata, v.edata);
    endtask

    initial begin
        vecs[0]  = '{2'd0, 32'h00001002, 4'hF, 1'b0, 32'h0,        32'hAABBCCDD, 12'hFFF, 1'b0, 4'b0100, 32'h0,        32'h000000BB, 12'h7FF};
        vecs[1]  = '{2'd1, 32'h00002002, 4'hF, 1'b1, 32'h00001234, 32'h99999999, 12'h012, 1'b0, 4'b1100, 32'h12340000, 32'h0,        12'h012};
        vecs[2]  = '{2'd2, 32'h00003001, 4'hF, 1'b0, 32'h0,        32'h0,        12'h0,   1'b1, 4'h0,    32'h0,        32'h0,        12'h800};
        vecs[3]  = '{2'd3, 32'h00004000, 4'hA, 1'b0, 32'h55667788, 32'hFFFFFFFF, 12'h001, 1'b0, 4'b1010, 32'h55667788, 32'hFF00FF00, 12'h001};
        vecs[4]  = '{2'd1, 32'h00005002, 4'hF, 1'b0, 32'h0,        32'hDEADBEEF, 12'h000, 1'b0, 4'b1100, 32'h0,        32'h0000DEAD, 12'h000};
        vecs[5]  = '{2'd0, 32'h00006003, 4'hF, 1'b1, 32'h000000A5, 32'h12345678, 12'h100, 1'b0, 4'b1000, 32'hA5000000, 32'h0,        12'h100};
        vecs[6]  = '{2'd1, 32'h00007001, 4'hF, 1'b0, 32'h0,        32'h0,        12'h0,   1'b1, 4'h0,    32'h0,        32'h0,        12'h800};
        vecs[7]  = '{2'd0, 32'h00008001, 4'h0, 1'b0, 32'h0,        32'h11223344, 12'h0A0, 1'b0, 4'b0000, 32'h0,        32'h00000033, 12'h0A0};
        vecs[8]  = '{2'd2, 32'h00009000, 4'h6, 1'b1, 32'hCAFEF00D, 32'h0,        12'h000, 1'b0, 4'b0110, 32'hCAFEF00D, 32'h0,        12'h000};
        vecs[9]  = '{2'd3, 32'h0000A002, 4'hF, 1'b0, 32'h0,        32'h0,        12'h0,   1'b1, 4'h0,    32'h0,        32'h0,        12'h800};
        vecs[10] = '{2'd2, 32'h0000B000, 4'hF, 1'b0, 32'h0,        32'h87654321, 12'h00F, 1'b0, 4'b1111, 32'h0,        32'h87654321, 12'h00F};
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", {31'h0, ldst_busy}, 32'h0);
        check("rst_valid", {31'h0, ldst_valid}, 32'h0);
        check("rst_data", ldst_rdata, 32'h0);
        check("rst_flags", {20'h0, ldst_flags}, 32'h0);
        check("rst_mem", {31'h0, mem_req} | {31'h0, mem_rw} | mem_addr | {28'h0, mem_mask} | mem_wdata, 32'h0);
        check("rst_mem_side", {18'h0, mem_tid} | {30'h0, mem_mmumod} | {29'h0, mem_mmups} | mem_pdt, 32'h0);
        // back-to-back: each vector starts the cycle right after the previous pulse
        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // memory back-pressure for three cycles, competing request while busy
        mem_busy = 1'b1;
        drive_req('{2'd1, 32'h0000C002, 4'hF, 1'b0, 32'h0, 32'h0, 12'h0, 1'b0, 4'h0, 32'h0, 32'h0, 12'h0}, 3);
        tick();
        ldst_addr = 32'h0000D000;
        ldst_order = 2'd2;
        for (int k = 0; k < 3; k++) begin
            check("bp_req", {31'h0, mem_req}, 32'h1);
            check("bp_addr", mem_addr, 32'h0000C000);
            check("bp_mask", {28'h0, mem_mask}, 32'hC);
            check("bp_busy", {31'h0, ldst_busy}, 32'h1);
            tick();
        end
        mem_busy = 1'b0;
        check("bp_handoff_req", {31'h0, mem_req}, 32'h1);
        mem_valid = 1'b1;
        mem_rdata = 32'h01020304;
        tick();
        ldst_req = 1'b0;
        mem_valid = 1'b0;
        check("handoff_valid_ignored", {31'h0, ldst_valid}, 32'h0);
        check("in_wait", {31'h0, mem_req, ldst_busy}, 32'h1);
        mem_valid = 1'b1;
        mem_rdata = 32'hBEEF5555;
        mem_flags = 12'h003;
        tick();
        mem_valid = 1'b0;
        check("bp_resp_valid", {31'h0, ldst_valid}, 32'h1);
        check("bp_resp_data", ldst_rdata, 32'h0000BEEF);
        check("bp_addr_kept", mem_addr, 32'h0000C000);
        tick();
        check("bp_idle", {31'h0, ldst_busy}, 32'h0);

        // reset while waiting on memory, then a stale response
        drive_req('{2'd2, 32'h0000E000, 4'hF, 1'b1, 32'h13579BDF, 32'h0, 12'h0, 1'b0, 4'h0, 32'h0, 32'h0, 12'h0}, 5);
        tick();
        ldst_req = 1'b0;
        tick();
        check("pre_rst_wait", {31'h0, ldst_busy}, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_valid = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        mem_flags = 12'hFFF;
        tick();
        mem_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check("rst_mid_valid", {31'h0, ldst_valid}, 32'h0);
            check("rst_mid_busy", {31'h0, ldst_busy}, 32'h0);
            check("rst_mid_data", ldst_rdata, 32'h0);
            check("rst_mid_flags", {20'h0, ldst_flags}, 32'h0);
            check("rst_mid_mem", {31'h0, mem_req} | {31'h0, mem_rw} | mem_addr | {28'h0, mem_mask} | mem_wdata, 32'h0);
            check("rst_mid_side", {18'h0, mem_tid} | {30'h0, mem_mmumod} | {29'h0, mem_mmups} | mem_pdt, 32'h0);
            tick();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/load_store_pipe_responder.md
# load_store_pipe_responder

Responder end of the load/store pipe: accepts one request at a time from the load/store pipe arbiter (REQ/BUSY handshake), converts ORDER/address/mask into a word-aligned byte-enabled memory transaction, issues it on the memory port, and returns the aligned, zero-extended result with MMU flags as a single-cycle VALID pulse. One transaction outstanding; sits between the arbiter and the data-side MMU/cache port.

## Interface
- No parameters; all widths fixed.
- iCLOCK  in  1  core clock
- iRESET_SYNC  in  1  synchronous reset, active-high
- iLDST_REQ  in  1  request from arbiter
- oLDST_BUSY  out  1  1 = cannot accept request this cycle
- iLDST_ORDER  in  2  00 byte, 01 halfword, 10 word, 11 raw masked word
- iLDST_MASK  in  4  upstream byte mask, ANDed into byte enables
- iLDST_RW  in  1  0 read, 1 write
- iLDST_TID / iLDST_MMUMOD / iLDST_MMUPS / iLDST_PDT  in  14/2/3/32  passed to memory port unchanged
- iLDST_ADDR  in  32  byte address
- iLDST_DATA  in  32  write data, right-justified
- oLDST_VALID  out  1  one-cycle response pulse
- oLDST_MMU_FLAGS  out  12  response flags; bit 11 = alignment fault
- oLDST_DATA  out  32  read data, right-justified, zero-extended
- oMEM_REQ  out  1  memory request, held until accepted
- iMEM_BUSY  in  1  memory not accepting
- oMEM_RW  out  1  0 read, 1 write
- oMEM_ADDR  out  32  {addr[31:2], 2'b00}
- oMEM_MASK  out  4  byte enables, lane n = bits [8n+7:8n]
- oMEM_DATA  out  32  lane-positioned write data
- oMEM_TID / oMEM_MMUMOD / oMEM_MMUPS / oMEM_PDT  out  14/2/3/32  latched copies
- iMEM_VALID  in  1  memory response
- iMEM_MMU_FLAGS  in  12  memory MMU flags
- iMEM_DATA  in  32  full read word

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. oLDST_BUSY = (state != IDLE).
- IDLE: iLDST_REQ=1 accepts and latches all request fields. Aligned -> ISSUE; misaligned -> RESP with fault.
- Little-endian lanes, a = addr[1:0]. Byte: base mask 0001<<a, write data = data[7:0]<<8a. Half: a[0] must be 0; mask 0011<<a, data[15:0]<<8a. Word: a must be 00; mask 1111. Raw (11): a must be 00; base mask 1111, data unshifted.
- oMEM_MASK = base mask & iLDST_MASK. Mask result 0000 is still issued (no special case).
- Misaligned = half with a[0]=1, or word/raw with a!=00: no memory access; response flags = 12'h800, data 0.
- ISSUE: oMEM_REQ=1 with latched outputs; when iMEM_BUSY=0 that cycle -> WAIT. Outputs stable while BUSY.
- WAIT: on iMEM_VALID latch flags (bit 11 forced 0) and read data -> RESP. iMEM_VALID in any other state ignored.
- Read extraction: byte = {24'h0, word>>8a [7:0]}; half = {16'h0, a[1]?word[31:16]:word[15:0]}; word = word; raw = word & byte-expanded mask. Writes return data 0.
- RESP: oLDST_VALID=1 for exactly one cycle -> IDLE.
- oLDST_DATA / oLDST_MMU_FLAGS registered, hold last value after the pulse.

## Timing
- Reset: state IDLE; oLDST_BUSY=0, oLDST_VALID=0, oLDST_DATA=0, oLDST_MMU_FLAGS=0, oMEM_REQ=0, all oMEM_* = 0.
- Accept at cycle T -> oMEM_REQ high from T+1; earliest hand-off T+1; earliest iMEM_VALID T+2; oLDST_VALID = iMEM_VALID cycle + 1; next accept the cycle after the pulse.
- Misaligned: accept T, oLDST_VALID at T+1, BUSY low at T+2.
- iMEM_VALID same cycle as hand-off (ISSUE) ignored; memory must respond ≥1 cycle later.
- Reset mid-transaction: immediate return to IDLE, no response emitted, later stale iMEM_VALID ignored.

## Test plan
- Byte read addr 0x1002, iMEM_DATA 0xAABBCCDD -> oMEM_ADDR 0x1000, oMEM_MASK 0100, oLDST_DATA 0x000000BB, flags bit11=0.
- Half write addr 0x2002, data 0x00001234, iLDST_MASK 1111 -> oMEM_MASK 1100, oMEM_DATA 0x12340000; VALID one cycle after iMEM_VALID, data 0.
- Word read addr 0x3001 -> no oMEM_REQ; oLDST_VALID at T+1, flags 0x800, data 0.
- iMEM_BUSY held 3 cycles in ISSUE -> oMEM_REQ/ADDR/MASK stable, oLDST_BUSY=1, hand-off on 4th cycle; iLDST_REQ during BUSY not accepted.
- Raw read mask 1010 addr 0x4000, word 0xFFFFFFFF -> oMEM_MASK 1010, data 0xFF00FF00; back-to-back request accepted cycle after VALID.
- iRESET_SYNC in WAIT, then iMEM_VALID -> no oLDST_VALID, all outputs at reset values.
